// File: rtl/pc_pkg.sv
// pc_pkg: shared types for the program-counter generator.
//   pc_state_e : fetch-control FSM states (boot, run, halt)
//   pc_sel_e   : which source the next PC was taken from, in priority order
package pc_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } pc_state_e;

    typedef enum logic [2:0] {
        SelTrap,
        SelMisalign,
        SelRedirect,
        SelSeq,
        SelHold
    } pc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: instruction-fetch request channel between the PC generator and
// instruction memory.
//   fetch_addr  : current fetch address (PC generator -> memory)
//   fetch_valid : request valid        (PC generator -> memory)
//   fetch_ready : request accepted     (memory -> PC generator)
// modport master is the PC generator side, slave the memory side.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);

    logic [XLEN-1:0] fetch_addr;
    logic            fetch_valid;
    logic            fetch_ready;

    modport master (
        output fetch_addr,
        output fetch_valid,
        input  fetch_ready
    );

    modport slave (
        input  fetch_addr,
        input  fetch_valid,
        output fetch_ready
    );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux with redirect alignment check.
//   pc              : current PC
//   running         : fetch request is being offered (RUN state)
//   fetch_ready     : memory accepts the current request
//   stall           : blocks sequential advance only
//   redirect_valid  : branch/jump taken, destination in redirect_target
//   trap_valid      : trap entry, handler base in trap_vec
//   next_pc         : PC value for the next cycle
//   sel             : source of next_pc
//   misalign        : redirect target had nonzero low alignment bits
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STEP       = 4,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic [XLEN-1:0] pc,
    input  logic            running,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    output logic [XLEN-1:0] next_pc,
    output pc_sel_e         sel,
    output logic            misalign
);

    // Ones in the low ALIGN_BITS positions; zero when ALIGN_BITS is 0.
    localparam logic [XLEN-1:0] AlignMask = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [XLEN-1:0] trap_base;
    logic            target_misaligned;
    logic            advance;

    always_comb begin
        trap_base         = trap_vec & ~AlignMask;
        target_misaligned = |(redirect_target & AlignMask);
        advance           = running & fetch_ready & ~stall;

        next_pc  = pc;
        sel      = SelHold;
        misalign = 1'b0;

        if (trap_valid) begin
            next_pc = trap_base;
            sel     = SelTrap;
        end else if (redirect_valid && target_misaligned) begin
            // A bad branch target is treated as a trap into the handler.
            next_pc  = trap_base;
            sel      = SelMisalign;
            misalign = 1'b1;
        end else if (redirect_valid) begin
            next_pc = redirect_target;
            sel     = SelRedirect;
        end else if (advance) begin
            // Wraps modulo 2^XLEN by construction.
            next_pc = pc + XLEN'(STEP);
            sel     = SelSeq;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
//   clk, rst        : clock, synchronous active-high reset
//   fetch           : fetch request channel (addr/valid out, ready in)
//   stall           : blocks sequential advance only
//   redirect_valid  : branch/jump taken; redirect_target is the destination
//   trap_valid      : trap entry; trap_vec is the handler base (low bits cleared)
//   halt_req/resume : enter/leave the halted state
//   halted          : high while halted
//   misalign        : one-cycle pulse after a misaligned redirect
//   badaddr         : last misaligned redirect target
// Redirects and traps update the PC in every state, including halt.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int unsigned     STEP       = 4,
    parameter int unsigned     ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    pc_gen_if.master        fetch,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            misalign,
    output logic [XLEN-1:0] badaddr
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic            misalign_q;
    logic [XLEN-1:0] badaddr_q;

    logic            running;
    logic [XLEN-1:0] next_pc;
    pc_sel_e         pc_sel;
    logic            misalign_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (halt_req) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                // halt_req wins over resume.
                if (resume && !halt_req) begin
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    // State-decoded outputs; these come straight from the state register.
    always_comb begin
        running = (state_q == StRun);
        halted  = (state_q == StHalt);
    end

    pc_next_sel #(
        .XLEN       (XLEN),
        .STEP       (STEP),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .pc              (pc_q),
        .running         (running),
        .fetch_ready     (fetch.fetch_ready),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vec        (trap_vec),
        .next_pc         (next_pc),
        .sel             (pc_sel),
        .misalign        (misalign_d)
    );

    // PC and misalign reporting registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            misalign_q <= 1'b0;
            badaddr_q  <= '0;
        end else begin
            if (pc_sel != SelHold) begin
                pc_q <= next_pc;
            end
            misalign_q <= misalign_d;
            if (misalign_d) begin
                badaddr_q <= redirect_target;
            end
        end
    end

    assign fetch.fetch_addr  = pc_q;
    assign fetch.fetch_valid = running;
    assign misalign          = misalign_q;
    assign badaddr           = badaddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with a behavioural reference model and
// hand-computed literal expectations checked from a single negedge process.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        misalign;
    logic [31:0] badaddr;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) fetch_bus ();

    pc_gen #(
        .XLEN       (32),
        .RESET_ADDR (32'h0000_0000),
        .STEP       (4),
        .ALIGN_BITS (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch           (fetch_bus),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .trap_vec        (trap_vec),
        .halt_req        (halt_req),
        .resume          (resume),
        .halted          (halted),
        .misalign        (misalign),
        .badaddr         (badaddr)
    );

    // Reference model: PC, booting/halted modes and misalign reporting.
    logic [31:0] m_pc;
    logic [31:0] m_bad;
    bit          m_boot;
    bit          m_halted;
    bit          m_mis;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        bit          offered;
        bit          accepted;
        logic [31:0] handler;
        if (rst) begin
            m_pc     = 32'h0;
            m_bad    = 32'h0;
            m_boot   = 1'b1;
            m_halted = 1'b0;
            m_mis    = 1'b0;
            m_live   = 1'b1;
        end else if (m_live) begin
            offered  = !m_boot && !m_halted;
            accepted = offered && fetch_bus.fetch_ready && !stall;
            handler  = {trap_vec[31:2], 2'b00};
            m_mis    = 1'b0;
            if (trap_valid) begin
                m_pc = handler;
            end else if (redirect_valid && (redirect_target % 4 != 0)) begin
                m_pc  = handler;
                m_mis = 1'b1;
                m_bad = redirect_target;
            end else if (redirect_valid) begin
                m_pc = redirect_target;
            end else if (accepted) begin
                m_pc = m_pc + 32'd4;
            end
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (!m_halted && halt_req) begin
                m_halted = 1'b1;
            end else if (m_halted && resume && !halt_req) begin
                m_halted = 1'b0;
            end
        end
    end

    // Literal expectations posted by the stimulus block.
    int          lit_tag  = 0;
    int          lit_done = 0;
    string       lit_name;
    logic [31:0] lit_addr;
    logic        lit_valid;
    logic        lit_halted;
    logic        lit_mis;
    logic [31:0] lit_bad;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            cmp("model_addr", fetch_bus.fetch_addr, m_pc);
            cmp("model_valid", {31'b0, fetch_bus.fetch_valid}, {31'b0, !m_boot && !m_halted});
            cmp("model_halted", {31'b0, halted}, {31'b0, m_halted});
            cmp("model_misalign", {31'b0, misalign}, {31'b0, m_mis});
            cmp("model_badaddr", badaddr, m_bad);
        end
        if (lit_tag != lit_done) begin
            lit_done = lit_tag;
            cmp({lit_name, "_addr"}, fetch_bus.fetch_addr, lit_addr);
            cmp({lit_name, "_valid"}, {31'b0, fetch_bus.fetch_valid}, {31'b0, lit_valid});
            cmp({lit_name, "_halted"}, {31'b0, halted}, {31'b0, lit_halted});
            cmp({lit_name, "_misalign"}, {31'b0, misalign}, {31'b0, lit_mis});
            cmp({lit_name, "_badaddr"}, badaddr, lit_bad);
            cmp({lit_name, "_model_pin"}, m_pc, lit_addr);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string name, input logic [31:0] addr, input logic valid,
                              input logic hlt, input logic mis, input logic [31:0] bad);
        lit_name   = name;
        lit_addr   = addr;
        lit_valid  = valid;
        lit_halted = hlt;
        lit_mis    = mis;
        lit_bad    = bad;
        lit_tag++;
    endtask

    initial begin
        rst                   = 1'b1;
        stall                 = 1'b0;
        redirect_valid        = 1'b0;
        redirect_target       = 32'h0;
        trap_valid            = 1'b0;
        trap_vec              = 32'h0;
        halt_req              = 1'b0;
        resume                = 1'b0;
        fetch_bus.fetch_ready = 1'b1;

        step(3);
        expect_lit("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        step(1); expect_lit("boot_first", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1); expect_lit("seq4", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1); expect_lit("seq8", 32'h8, 1'b1, 1'b0, 1'b0, 32'h0);
        step(2); expect_lit("at10", 32'h10, 1'b1, 1'b0, 1'b0, 32'h0);

        fetch_bus.fetch_ready = 1'b0;
        step(3); expect_lit("backpressure", 32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        fetch_bus.fetch_ready = 1'b1;
        stall = 1'b1;
        step(2); expect_lit("stall_hold", 32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        stall = 1'b0;
        step(1); expect_lit("unstall", 32'h14, 1'b1, 1'b0, 1'b0, 32'h0);
        step(3); expect_lit("at20", 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);

        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        step(1); expect_lit("redir_hs", 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);

        trap_valid      = 1'b1;
        trap_vec        = 32'h103;
        redirect_target = 32'h300;
        step(1); expect_lit("trap_prio", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        trap_valid = 1'b0;

        trap_vec        = 32'h100;
        redirect_target = 32'h42;
        step(1); expect_lit("misalign", 32'h100, 1'b1, 1'b0, 1'b1, 32'h42);
        redirect_valid = 1'b0;
        step(1); expect_lit("mis_clear", 32'h104, 1'b1, 1'b0, 1'b0, 32'h42);

        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step(1); expect_lit("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h42);
        redirect_valid = 1'b0;
        step(1); expect_lit("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 32'h42);

        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        step(1); expect_lit("at40", 32'h40, 1'b1, 1'b0, 1'b0, 32'h42);
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        // The handshake at the halting edge still advances the PC.
        step(1); expect_lit("halt", 32'h44, 1'b0, 1'b1, 1'b0, 32'h42);
        halt_req = 1'b0;
        step(1); expect_lit("halt_hold", 32'h44, 1'b0, 1'b1, 1'b0, 32'h42);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step(1); expect_lit("halt_redir", 32'h200, 1'b0, 1'b1, 1'b0, 32'h42);
        redirect_valid = 1'b0;
        resume         = 1'b1;
        halt_req       = 1'b1;
        step(1); expect_lit("both_high", 32'h200, 1'b0, 1'b1, 1'b0, 32'h42);
        halt_req = 1'b0;
        step(1); expect_lit("resume", 32'h200, 1'b1, 1'b0, 1'b0, 32'h42);
        resume = 1'b0;
        step(1); expect_lit("post_resume", 32'h204, 1'b1, 1'b0, 1'b0, 32'h42);
        halt_req = 1'b1;
        step(1); expect_lit("halt2", 32'h208, 1'b0, 1'b1, 1'b0, 32'h42);
        halt_req = 1'b0;
        rst      = 1'b1;
        step(1); expect_lit("rst_in_halt", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        step(1); expect_lit("reboot", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1); expect_lit("reboot_seq", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
